his_builder_mc: RTL and testbench

//  Multi-channel dToF histogram builder with coarse/fine modes, saturating bins, per-channel peak tracking.

---
 rtl/his_builder_mc.sv | 184 ++++++++++++++++++
 tb/tb_his_builder_mc.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/his_builder_mc.sv
// Multi-channel dToF histogram builder: per-channel coarse/fine binning with saturating counters,
// peak tracking and a drop counter, drained bin by bin over a valid/ready port at acquisition end.
module his_builder_mc #(
  parameter  int NUM_CH       = 2,
  parameter  int NUM_BINS     = 8,
  parameter  int ADDR_W       = 6,
  parameter  int CNT_W        = 4,
  parameter  int COARSE_SHIFT = 3,
  localparam int BIN_W        = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1,
  localparam int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                      clk,
  input  logic                      res,
  input  logic [NUM_CH-1:0]         wr_en,
  input  logic [NUM_CH*ADDR_W-1:0]  addr,
  input  logic                      mode,
  input  logic [ADDR_W-1:0]         fine_base,
  input  logic                      acq_finish,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CH_W-1:0]           out_ch,
  output logic [BIN_W-1:0]          out_bin,
  output logic [CNT_W-1:0]          out_count,
  output logic [NUM_CH*BIN_W-1:0]   peak_bin,
  output logic [7:0]                drop_cnt,
  output logic                      busy,
  output logic                      done
);

  localparam logic [1:0] ST_ACQ   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [ADDR_W:0]   NB_EXT   = (ADDR_W+1)'(NUM_BINS);
  localparam logic [CH_W-1:0]   LAST_CH  = CH_W'(NUM_CH - 1);
  localparam logic [BIN_W-1:0]  LAST_BIN = BIN_W'(NUM_BINS - 1);

  logic [1:0]        state_q, state_d;
  logic [CH_W-1:0]   rd_ch_q, rd_ch_d;
  logic [BIN_W-1:0]  rd_bin_q, rd_bin_d;
  logic [7:0]        drop_q, drop_d;

  logic [CNT_W-1:0]  bin_q      [NUM_CH][NUM_BINS];
  logic [CNT_W-1:0]  peak_cnt_q [NUM_CH];
  logic [BIN_W-1:0]  peak_bin_q [NUM_CH];

  logic [ADDR_W-1:0] chAddr    [NUM_CH];
  logic [ADDR_W-1:0] coarseIdx [NUM_CH];
  logic [ADDR_W:0]   fineDiff  [NUM_CH];
  logic [BIN_W-1:0]  wIdx      [NUM_CH];
  logic [CNT_W-1:0]  wCnt      [NUM_CH];
  logic [NUM_CH-1:0] inRange;
  logic [NUM_CH-1:0] hit;
  logic [NUM_CH-1:0] miss;

  logic [8:0]        dropInc;
  logic [8:0]        dropSum;
  logic              accept;
  logic              lastWord;

  // Fine mode subtracts one bit wider so a borrow flags addresses below the window start.
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      chAddr[k]    = addr[k*ADDR_W +: ADDR_W];
      coarseIdx[k] = chAddr[k] >> COARSE_SHIFT;
      fineDiff[k]  = {1'b0, chAddr[k]} - {1'b0, fine_base};
      if (mode) begin
        inRange[k] = !fineDiff[k][ADDR_W] && (fineDiff[k] < NB_EXT);
        wIdx[k]    = fineDiff[k][BIN_W-1:0];
      end else begin
        inRange[k] = ({1'b0, coarseIdx[k]} < NB_EXT);
        wIdx[k]    = coarseIdx[k][BIN_W-1:0];
      end
      hit[k]  = (state_q == ST_ACQ) && wr_en[k] && inRange[k];
      miss[k] = (state_q == ST_ACQ) && wr_en[k] && !inRange[k];
      wCnt[k] = (bin_q[k][wIdx[k]] == CNT_MAX) ? CNT_MAX : bin_q[k][wIdx[k]] + CNT_W'(1);
    end
  end

  always_comb begin
    dropInc = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (miss[k]) dropInc = dropInc + 9'd1;
    end
    dropSum = {1'b0, drop_q} + dropInc;
    drop_d  = (dropSum > 9'd255) ? 8'hFF : dropSum[7:0];
  end

  assign accept   = out_valid && out_ready;
  assign lastWord = (rd_ch_q == LAST_CH) && (rd_bin_q == LAST_BIN);

  always_comb begin
    state_d  = state_q;
    rd_ch_d  = rd_ch_q;
    rd_bin_d = rd_bin_q;
    case (state_q)
      ST_ACQ: begin
        if (acq_finish) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (accept) begin
          if (lastWord) begin
            state_d  = ST_DONE;
            rd_ch_d  = '0;
            rd_bin_d = '0;
          end else if (rd_bin_q == LAST_BIN) begin
            rd_bin_d = '0;
            rd_ch_d  = rd_ch_q + CH_W'(1);
          end else begin
            rd_bin_d = rd_bin_q + BIN_W'(1);
          end
        end
      end
      ST_DONE:  state_d = ST_ACQ;
      default:  state_d = ST_ACQ;
    endcase
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q  <= ST_ACQ;
      rd_ch_q  <= '0;
      rd_bin_q <= '0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      rd_ch_q  <= rd_ch_d;
      rd_bin_q <= rd_bin_d;
      drop_q   <= (state_q == ST_DONE) ? 8'd0 : drop_d;
    end
  end

  // Acquisition writes and readout clears never coincide because they belong to different states.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      for (int k = 0; k < NUM_CH; k++) begin
        for (int b = 0; b < NUM_BINS; b++) begin
          bin_q[k][b] <= '0;
        end
      end
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (hit[k]) bin_q[k][wIdx[k]] <= wCnt[k];
      end
      if (accept) bin_q[rd_ch_q][rd_bin_q] <= '0;
    end
  end

  // Strict comparison keeps the earliest bin on ties.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      for (int k = 0; k < NUM_CH; k++) begin
        peak_cnt_q[k] <= '0;
        peak_bin_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (state_q == ST_DONE) begin
          peak_cnt_q[k] <= '0;
          peak_bin_q[k] <= '0;
        end else if (hit[k] && (wCnt[k] > peak_cnt_q[k])) begin
          peak_cnt_q[k] <= wCnt[k];
          peak_bin_q[k] <= wIdx[k];
        end
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      peak_bin[k*BIN_W +: BIN_W] = peak_bin_q[k];
    end
  end

  assign out_valid = (state_q == ST_DRAIN);
  assign busy      = (state_q == ST_DRAIN);
  assign done      = (state_q == ST_DONE);
  assign out_ch    = rd_ch_q;
  assign out_bin   = rd_bin_q;
  assign out_count = out_valid ? bin_q[rd_ch_q][rd_bin_q] : '0;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_his_builder_mc.sv
// Directed bench for his_builder_mc: coarse/fine binning, saturation, ties, backpressure and
// reset during readout, with expected histograms written out by hand per scenario.
module tb_his_builder_mc;

  logic        clk = 1'b0;
  logic        res;
  logic [1:0]  wr_en;
  logic [11:0] addr;
  logic        mode;
  logic [5:0]  fine_base;
  logic        acq_finish;
  logic        out_valid;
  logic        out_ready;
  logic [0:0]  out_ch;
  logic [2:0]  out_bin;
  logic [3:0]  out_count;
  logic [5:0]  peak_bin;
  logic [7:0]  drop_cnt;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  his_builder_mc dut (
    .clk        (clk),
    .res        (res),
    .wr_en      (wr_en),
    .addr       (addr),
    .mode       (mode),
    .fine_base  (fine_base),
    .acq_finish (acq_finish),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_ch     (out_ch),
    .out_bin    (out_bin),
    .out_count  (out_count),
    .peak_bin   (peak_bin),
    .drop_cnt   (drop_cnt),
    .busy       (busy),
    .done       (done)
  );

  int total = 0;
  int bad   = 0;

  int          nWords;
  int          stallBad;
  int          donePos;
  int          lastWordCyc;
  logic        doneAfter;
  logic [5:0]  peakSnap;
  logic [7:0]  dropSnap;
  logic [3:0]  gotKey [16];
  logic [3:0]  gotCnt [16];
  int          expCnt [16];

  // One sample on one channel for one cycle.
  task automatic put(input int ch, input logic [5:0] a);
    wr_en = '0;
    wr_en[ch] = 1'b1;
    addr[ch*6 +: 6] = a;
    @(negedge clk);
    wr_en = '0;
  endtask

  // Pulses acq_finish (together with whatever wr_en the caller left set) and collects the readout.
  task automatic drain(input bit rnd);
    logic       pStall;
    logic [0:0] pCh;
    logic [2:0] pBin;
    logic [3:0] pCnt;
    logic       r;
    nWords = 0; stallBad = 0; donePos = -1; lastWordCyc = -1;
    pStall = 1'b0; pCh = '0; pBin = '0; pCnt = '0;
    for (int i = 0; i < 16; i++) begin
      gotKey[i] = 'x;
      gotCnt[i] = 'x;
    end
    acq_finish = 1'b1;
    @(negedge clk);
    acq_finish = 1'b0;
    wr_en = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (done === 1'b1) begin
        donePos  = cyc;
        peakSnap = peak_bin;
        dropSnap = drop_cnt;
        break;
      end
      if (out_valid === 1'b1) begin
        if (pStall && (out_ch !== pCh || out_bin !== pBin || out_count !== pCnt)) stallBad++;
        if (!rnd) r = 1'b1;
        else if (cyc < 2) r = 1'b0;
        else r = 1'($urandom_range(0, 1));
        out_ready = r;
        if (r) begin
          if (nWords < 16) begin
            gotKey[nWords] = {out_ch, out_bin};
            gotCnt[nWords] = out_count;
          end
          nWords++;
          lastWordCyc = cyc;
        end
        pStall = !r; pCh = out_ch; pBin = out_bin; pCnt = out_count;
      end else begin
        out_ready = 1'b0;
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    @(negedge clk);
    doneAfter = done;
  endtask

  task automatic clear_exp();
    for (int i = 0; i < 16; i++) expCnt[i] = 0;
  endtask

  task automatic test_reset();
    res = 1'b1; wr_en = '0; addr = '0; mode = 1'b0; fine_base = '0;
    acq_finish = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    total++; if ({out_valid, busy, done} !== 3'b000) begin bad++; $display("FAIL reset_flags: got %b want 000", {out_valid, busy, done}); end
    total++; if ({out_ch, out_bin, out_count} !== 8'd0) begin bad++; $display("FAIL reset_word: got %h want 00", {out_ch, out_bin, out_count}); end
    total++; if (peak_bin !== 6'd0) begin bad++; $display("FAIL reset_peak: got %0d want 0", peak_bin); end
    total++; if (drop_cnt !== 8'd0) begin bad++; $display("FAIL reset_drop: got %0d want 0", drop_cnt); end
    res = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_coarse();
    mode = 1'b0;
    wr_en = 2'b11; addr = {6'd63, 6'd9};
    @(negedge clk);
    wr_en = '0;
    put(0, 6'd9);
    put(0, 6'd17);
    clear_exp(); expCnt[1] = 2; expCnt[2] = 1; expCnt[15] = 1;
    drain(1'b0);
    total++; if (nWords !== 16) begin bad++; $display("FAIL coarse_nwords: got %0d want 16", nWords); end
    for (int i = 0; i < 16; i++) begin
      total++; if (gotKey[i] !== 4'(i) || gotCnt[i] !== 4'(expCnt[i])) begin bad++; $display("FAIL coarse_word%0d: got key=%0d cnt=%0d want key=%0d cnt=%0d", i, gotKey[i], gotCnt[i], i, expCnt[i]); end
    end
    total++; if (donePos !== lastWordCyc + 1) begin bad++; $display("FAIL coarse_done_timing: got %0d want %0d", donePos, lastWordCyc + 1); end
    total++; if (doneAfter !== 1'b0) begin bad++; $display("FAIL coarse_done_pulse: got %b want 0", doneAfter); end
    total++; if (peakSnap !== 6'b111_001) begin bad++; $display("FAIL coarse_peak: got %b want 111001", peakSnap); end
    total++; if (dropSnap !== 8'd0) begin bad++; $display("FAIL coarse_drop: got %0d want 0", dropSnap); end
    total++; if (peak_bin !== 6'd0) begin bad++; $display("FAIL coarse_peak_clear: got %0d want 0", peak_bin); end
  endtask

  task automatic test_fine();
    mode = 1'b1; fine_base = 6'd20;
    put(0, 6'd19);
    put(0, 6'd20);
    put(0, 6'd27);
    put(0, 6'd28);
    wr_en = 2'b11; addr = {6'd0, 6'd63};
    @(negedge clk);
    wr_en = '0;
    clear_exp(); expCnt[0] = 1; expCnt[7] = 1;
    drain(1'b0);
    total++; if (nWords !== 16) begin bad++; $display("FAIL fine_nwords: got %0d want 16", nWords); end
    for (int i = 0; i < 16; i++) begin
      total++; if (gotKey[i] !== 4'(i) || gotCnt[i] !== 4'(expCnt[i])) begin bad++; $display("FAIL fine_word%0d: got key=%0d cnt=%0d want key=%0d cnt=%0d", i, gotKey[i], gotCnt[i], i, expCnt[i]); end
    end
    total++; if (dropSnap !== 8'd4) begin bad++; $display("FAIL fine_drop: got %0d want 4", dropSnap); end
    total++; if (peakSnap !== 6'd0) begin bad++; $display("FAIL fine_peak: got %b want 000000", peakSnap); end
    total++; if (drop_cnt !== 8'd0) begin bad++; $display("FAIL fine_drop_clear: got %0d want 0", drop_cnt); end
    mode = 1'b0; fine_base = '0;
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 20; i++) put(1, 6'd8);
    clear_exp(); expCnt[9] = 15;
    drain(1'b0);
    total++; if (nWords !== 16) begin bad++; $display("FAIL sat_nwords: got %0d want 16", nWords); end
    for (int i = 0; i < 16; i++) begin
      total++; if (gotKey[i] !== 4'(i) || gotCnt[i] !== 4'(expCnt[i])) begin bad++; $display("FAIL sat_word%0d: got key=%0d cnt=%0d want key=%0d cnt=%0d", i, gotKey[i], gotCnt[i], i, expCnt[i]); end
    end
    total++; if (peakSnap !== 6'b001_000) begin bad++; $display("FAIL sat_peak: got %b want 001000", peakSnap); end
  endtask

  task automatic test_back_to_back();
    repeat (3) put(0, 6'd0);
    put(1, 6'd40);
    put(0, 6'd56);
    clear_exp(); expCnt[0] = 3; expCnt[13] = 1; expCnt[7] = 1;
    drain(1'b1);
    total++; if (nWords !== 16) begin bad++; $display("FAIL bp_nwords: got %0d want 16", nWords); end
    for (int i = 0; i < 16; i++) begin
      total++; if (gotKey[i] !== 4'(i) || gotCnt[i] !== 4'(expCnt[i])) begin bad++; $display("FAIL bp_word%0d: got key=%0d cnt=%0d want key=%0d cnt=%0d", i, gotKey[i], gotCnt[i], i, expCnt[i]); end
    end
    total++; if (stallBad !== 0) begin bad++; $display("FAIL bp_stall_stable: got %0d changes want 0", stallBad); end
    total++; if (donePos !== lastWordCyc + 1) begin bad++; $display("FAIL bp_done_timing: got %0d want %0d", donePos, lastWordCyc + 1); end
    total++; if (peakSnap !== 6'b101_000) begin bad++; $display("FAIL bp_peak: got %b want 101000", peakSnap); end
    put(1, 6'd16);
    clear_exp(); expCnt[10] = 1;
    drain(1'b0);
    total++; if (nWords !== 16) begin bad++; $display("FAIL bp2_nwords: got %0d want 16", nWords); end
    for (int i = 0; i < 16; i++) begin
      total++; if (gotKey[i] !== 4'(i) || gotCnt[i] !== 4'(expCnt[i])) begin bad++; $display("FAIL bp2_word%0d: got key=%0d cnt=%0d want key=%0d cnt=%0d", i, gotKey[i], gotCnt[i], i, expCnt[i]); end
    end
    total++; if (peakSnap !== 6'b010_000) begin bad++; $display("FAIL bp2_peak: got %b want 010000", peakSnap); end
  endtask

  task automatic test_tie();
    put(0, 6'd8);
    put(0, 6'd16);
    wr_en = 2'b01; addr[5:0] = 6'd16;
    clear_exp(); expCnt[1] = 1; expCnt[2] = 2;
    drain(1'b0);
    for (int i = 0; i < 16; i++) begin
      total++; if (gotKey[i] !== 4'(i) || gotCnt[i] !== 4'(expCnt[i])) begin bad++; $display("FAIL tie_word%0d: got key=%0d cnt=%0d want key=%0d cnt=%0d", i, gotKey[i], gotCnt[i], i, expCnt[i]); end
    end
    total++; if (peakSnap !== 6'b000_010) begin bad++; $display("FAIL tie_same_cycle_peak: got %b want 000010", peakSnap); end
    put(0, 6'd8);
    put(0, 6'd16);
    drain(1'b0);
    total++; if (peakSnap !== 6'b000_001) begin bad++; $display("FAIL tie_first_peak: got %b want 000001", peakSnap); end
  endtask

  task automatic test_reset_mid_drain();
    put(0, 6'd0);
    put(0, 6'd0);
    put(1, 6'd63);
    acq_finish = 1'b1;
    @(negedge clk);
    acq_finish = 1'b0;
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    total++; if ({busy, out_bin} !== 4'b1_101) begin bad++; $display("FAIL rst_drain_pos: got busy/bin=%b want 1101", {busy, out_bin}); end
    res = 1'b1;
    #1;
    total++; if ({out_valid, busy, out_count} !== 6'd0) begin bad++; $display("FAIL rst_drain_abort: got %b want 000000", {out_valid, busy, out_count}); end
    @(negedge clk);
    res = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    put(0, 6'd24);
    clear_exp(); expCnt[3] = 1;
    drain(1'b0);
    total++; if (nWords !== 16) begin bad++; $display("FAIL rst_nwords: got %0d want 16", nWords); end
    for (int i = 0; i < 16; i++) begin
      total++; if (gotKey[i] !== 4'(i) || gotCnt[i] !== 4'(expCnt[i])) begin bad++; $display("FAIL rst_word%0d: got key=%0d cnt=%0d want key=%0d cnt=%0d", i, gotKey[i], gotCnt[i], i, expCnt[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_coarse();
    test_fine();
    test_saturation();
    test_back_to_back();
    test_tie();
    test_reset_mid_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

endmodule
